crc_frame_engine: RTL and testbench
===================================

CRC_FRAME_ENGINE -- requirements
Module: crc_frame_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 16, CRC register width (8..32).
REQ-002 SHALL have parameter POLY, default 16'h1021, generator polynomial, MSB-first (implicit x^CRC_W term).
REQ-003 SHALL have parameter INIT, default 16'hFFFF, CRC register value at reset and at each frame start.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16, input buffer entries (power of 2, >= 2).
REQ-005 SHALL have parameter BITS_PER_CLK, default 1, bits folded into the CRC per SHIFT cycle (1, 2, 4 or 8).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port byte_in  input  8  data byte to enqueue.
REQ-009 SHALL have port byte_last  input  1  marks byte_in as the final byte of a frame.
REQ-010 SHALL have port wrreq  input  1  enqueue request.
REQ-011 SHALL have port crc_en  input  1  engine run enable; low stalls the engine, FIFO still accepts writes.
REQ-012 SHALL have port buffer_full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-013 SHALL have port buffer_count  output  log2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-014 SHALL have port overflow  output  1  sticky: a write was dropped.
REQ-015 SHALL have port crc_done  output  1  one-cycle pulse, frame CRC complete.
REQ-016 SHALL have port crc_value  output  CRC_W  CRC of last completed frame.

Function
REQ-017 FIFO SHALL store {byte_last, byte_in} when wrreq=1 and buffer_full=0; wrreq with buffer_full=1 SHALL drop the byte and set overflow.
REQ-018 buffer_full SHALL be evaluated before the same-cycle pop: a full FIFO rejects writes even when a pop occurs that cycle.
REQ-019 A write to an empty FIFO SHALL become visible to the engine no earlier than the following cycle.
REQ-020 Engine FSM SHALL have states IDLE, SHIFT, DONE.
REQ-021 IDLE: if crc_en=1 and FIFO non-empty, pop one entry into the shift register and go to SHIFT; else stay.
REQ-022 SHIFT: when crc_en=1, fold BITS_PER_CLK bits MSB-first into the CRC register (feedback = crc MSB XOR data bit, XOR POLY when set); crc_en=0 freezes all engine state.
REQ-023 After 8/BITS_PER_CLK active SHIFT cycles: go to DONE if the byte's last flag is set, else go to IDLE.
REQ-024 DONE (one cycle): crc_done=1, crc_value <= CRC register, CRC register <= INIT; next state IDLE regardless of crc_en.
REQ-025 Cycles per byte with crc_en held high SHALL be 1 (IDLE pop) + 8/BITS_PER_CLK; last byte adds 1 DONE cycle.
REQ-026 crc_value SHALL hold its value between crc_done pulses; no reflection, no final XOR.
REQ-027 A frame of one byte with byte_last=1 SHALL be valid; successive frames SHALL NOT share CRC state.

Reset
REQ-028 rst=1 SHALL asynchronously clear the FIFO (count 0, pointers 0), overflow=0, crc_done=0, crc_value=0, CRC register=INIT, FSM=IDLE.
REQ-029 Reset mid-frame SHALL discard the partial frame and all buffered bytes; no crc_done SHALL be produced for it.

Configuration
REQ-030 With macro CRC_FRAME_CHECK_EN defined, SHALL add input crc_expected[CRC_W-1:0] and output crc_match (1), registered in DONE as (CRC register == crc_expected), held until next DONE, reset 0.
REQ-031 Without CRC_FRAME_CHECK_EN, crc_expected and crc_match SHALL be absent and all other behaviour identical.

Verification
REQ-032 Defaults, crc_en=1, ASCII "123456789" (last on '9') -> one crc_done pulse, crc_value=16'h29B1.
REQ-033 Defaults, single byte 8'h00 with byte_last=1 -> crc_done 10 cycles after the pop cycle's IDLE entry, crc_value=16'hE1F0.
REQ-034 crc_en=0, write 17 bytes -> buffer_full=1 and buffer_count=16 after 16th write, 17th dropped, overflow=1; raise crc_en -> 16 bytes drain, overflow stays 1.
REQ-035 BITS_PER_CLK=8, "123456789" back-to-back -> crc_value=16'h29B1, done 19 cycles after first pop (9 x 2 + 1).
REQ-036 Assert rst during SHIFT of byte 5 of a frame -> outputs at reset values, no crc_done; next "123456789" frame -> 16'h29B1.
REQ-037 CRC_FRAME_CHECK_EN, crc_expected=16'h29B1, "123456789" -> crc_match=1; crc_expected=16'h29B0 -> crc_match=0.

Source files
------------

// File: rtl/crc_frame_engine.sv
// Byte-buffered frame CRC engine: a FIFO feeds a bit-serial (or multi-bit) MSB-first CRC folder.
// Optional CRC_FRAME_CHECK_EN adds a compare against crc_expected reported on crc_match.
module crc_frame_engine #(
    parameter int unsigned      CRC_W        = 16,
    parameter logic [CRC_W-1:0] POLY         = 16'h1021,
    parameter logic [CRC_W-1:0] INIT         = 16'hFFFF,
    parameter int unsigned      FIFO_DEPTH   = 16,
    parameter int unsigned      BITS_PER_CLK = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_last,
    input  logic                          wrreq,
    input  logic                          crc_en,
    output logic                          buffer_full,
    output logic [$clog2(FIFO_DEPTH):0]   buffer_count,
    output logic                          overflow,
    output logic                          crc_done,
    output logic [CRC_W-1:0]              crc_value
`ifdef CRC_FRAME_CHECK_EN
    ,
    input  logic [CRC_W-1:0]              crc_expected,
    output logic                          crc_match
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned SHIFT_CYCLES = 8 / BITS_PER_CLK;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [2:0] LAST_CNT = 3'(SHIFT_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q;
    logic             push, pop;
    logic [8:0]       rd_data;
    state_e           state_q;

    // Fullness comes from the registered count, so a same-cycle pop never frees a slot for a write.
    assign buffer_full  = (count_q == FULL_CNT);
    assign buffer_count = count_q;
    assign overflow     = overflow_q;
    assign push         = wrreq && !buffer_full;
    assign pop          = (state_q == StIdle) && crc_en && (count_q != '0);
    assign rd_data      = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {byte_last, byte_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (wrreq && buffer_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // CRC fold of BITS_PER_CLK data bits, MSB first
    // ------------------------------------------------------------------
    logic [7:0]       shreg_q;
    logic             last_q;
    logic [2:0]       bit_cnt_q;
    logic [CRC_W-1:0] crc_q, crc_fold, crc_value_q;
    logic             crc_done_q;
    logic             fb;

    always_comb begin
        crc_fold = crc_q;
        fb       = 1'b0;
        for (int i = 0; i < int'(BITS_PER_CLK); i++) begin
            fb       = crc_fold[CRC_W-1] ^ shreg_q[7-i];
            crc_fold = {crc_fold[CRC_W-2:0], 1'b0};
            if (fb) begin
                crc_fold = crc_fold ^ POLY;
            end
        end
    end

    assign crc_done  = crc_done_q;
    assign crc_value = crc_value_q;

`ifdef CRC_FRAME_CHECK_EN
    logic crc_match_q;
    assign crc_match = crc_match_q;
`endif

    // ------------------------------------------------------------------
    // Engine FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            last_q      <= 1'b0;
            bit_cnt_q   <= '0;
            crc_q       <= INIT;
            crc_value_q <= '0;
            crc_done_q  <= 1'b0;
`ifdef CRC_FRAME_CHECK_EN
            crc_match_q <= 1'b0;
`endif
        end else begin
            crc_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pop) begin
                        shreg_q   <= rd_data[7:0];
                        last_q    <= rd_data[8];
                        bit_cnt_q <= '0;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    // crc_en low freezes every piece of engine state here.
                    if (crc_en) begin
                        crc_q   <= crc_fold;
                        shreg_q <= shreg_q << BITS_PER_CLK;
                        if (bit_cnt_q == LAST_CNT) begin
                            state_q <= last_q ? StDone : StIdle;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                StDone: begin
                    crc_done_q  <= 1'b1;
                    crc_value_q <= crc_q;
                    crc_q       <= INIT;
                    state_q     <= StIdle;
`ifdef CRC_FRAME_CHECK_EN
                    crc_match_q <= (crc_q == crc_expected);
`endif
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_engine.sv
// Directed bench for crc_frame_engine; optional checks run when CRC_FRAME_CHECK_EN is defined.
module tb_crc_frame_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
    logic        byte_last;
    logic        wrreq, wrreq8;
    logic        crc_en, crc_en8;
    logic        buffer_full, buffer_full8;
    logic [4:0]  buffer_count, buffer_count8;
    logic        overflow, overflow8;
    logic        crc_done, crc_done8;
    logic [15:0] crc_value, crc_value8;
`ifdef CRC_FRAME_CHECK_EN
    logic [15:0] crc_exp;
    logic        crc_match, crc_match8;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done8_cnt = 0;
    int cyc = 0;
    int done8_cyc = -1;
    logic [15:0] vals[$];
    logic [7:0]  msg [9];

    always #5 clk = ~clk;

    crc_frame_engine u_dut (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_last    (byte_last),
        .wrreq        (wrreq),
        .crc_en       (crc_en),
        .buffer_full  (buffer_full),
        .buffer_count (buffer_count),
        .overflow     (overflow),
        .crc_done     (crc_done),
        .crc_value    (crc_value)
`ifdef CRC_FRAME_CHECK_EN
        ,
        .crc_expected (crc_exp),
        .crc_match    (crc_match)
`endif
    );

    crc_frame_engine #(.BITS_PER_CLK(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .byte_in      (byte_in),
        .byte_last    (byte_last),
        .wrreq        (wrreq8),
        .crc_en       (crc_en8),
        .buffer_full  (buffer_full8),
        .buffer_count (buffer_count8),
        .overflow     (overflow8),
        .crc_done     (crc_done8),
        .crc_value    (crc_value8)
`ifdef CRC_FRAME_CHECK_EN
        ,
        .crc_expected (crc_exp),
        .crc_match    (crc_match8)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (crc_done === 1'b1) begin
            done_cnt = done_cnt + 1;
            vals.push_back(crc_value);
        end
        if (crc_done8 === 1'b1) begin
            done8_cnt = done8_cnt + 1;
            if (done8_cyc < 0) done8_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b, input logic l, input bit to8);
        byte_in   = b;
        byte_last = l;
        if (to8) wrreq8 = 1'b1;
        else     wrreq  = 1'b1;
        @(posedge clk);
        #1;
        wrreq  = 1'b0;
        wrreq8 = 1'b0;
    endtask

    task automatic write_msg(input bit to8);
        for (int i = 0; i < 9; i++) write_byte(msg[i], (i == 8), to8);
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int n = 0; n < budget && done_cnt < target; n++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int base;
        int w_cyc;
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rst = 1'b1; byte_in = '0; byte_last = 1'b0; wrreq = 1'b0; wrreq8 = 1'b0;
        crc_en = 1'b0; crc_en8 = 1'b0;
`ifdef CRC_FRAME_CHECK_EN
        crc_exp = 16'h29B1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", buffer_count, 0);
        check("rst_full", buffer_full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", crc_done, 0);
        check("rst_value", crc_value, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single zero byte: done 10 edges after the pop cycle begins.
        crc_en = 1'b1;
        write_byte(8'h00, 1'b1, 1'b0);
        n = 0;
        while (crc_done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("single_latency", n, 10);
        check("single_value", crc_value, 16'hE1F0);
        @(posedge clk);
        #1;
        check("single_pulse_cnt", done_cnt, 1);

        // Standard check string.
        base = done_cnt;
        write_msg(1'b0);
        wait_done(base + 1, 200);
        check("msg_value", crc_value, 16'h29B1);
        repeat (20) @(posedge clk);
        #1;
        check("msg_hold", crc_value, 16'h29B1);
        check("msg_pulse_cnt", done_cnt - base, 1);

        // Fill with engine stalled, then write on the same cycle the engine pops.
        crc_en = 1'b0;
        base = done_cnt;
        write_msg(1'b0);
        for (int i = 0; i < 7; i++) write_byte(8'h00, 1'b1, 1'b0);
        check("fill_count", buffer_count, 16);
        check("fill_full", buffer_full, 1);
        check("fill_no_overflow", overflow, 0);
        crc_en = 1'b1;
        write_byte(8'hFF, 1'b1, 1'b0);
        check("drop_overflow", overflow, 1);
        check("drop_count", buffer_count, 15);
        check("drop_full", buffer_full, 0);
        wait_done(base + 8, 400);
        repeat (20) @(posedge clk);
        #1;
        check("drain_frames", done_cnt - base, 8);
        check("drain_first", vals[base], 16'h29B1);
        check("drain_last", crc_value, 16'hE1F0);
        check("drain_count", buffer_count, 0);
        check("drain_overflow_sticky", overflow, 1);

        // Engine paused intermittently mid-shift.
        base = done_cnt;
        write_msg(1'b0);
        for (int i = 0; i < 400 && done_cnt == base; i++) begin
            crc_en = (i % 3 == 2) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        crc_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("stall_frames", done_cnt - base, 1);
        check("stall_value", crc_value, 16'h29B1);

        // Reset while the fifth byte is shifting.
        base = done_cnt;
        write_msg(1'b0);
        repeat (32) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check("midrst_count", buffer_count, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_done", crc_done, 0);
        check("midrst_value", crc_value, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_done", done_cnt - base, 0);
        write_msg(1'b0);
        wait_done(base + 1, 200);
        check("postrst_value", crc_value, 16'h29B1);
        check("postrst_frames", done_cnt - base, 1);

        // Byte-wide fold, back-to-back bytes.
        crc_en8 = 1'b1;
        write_byte(msg[0], 1'b0, 1'b1);
        w_cyc = cyc;
        for (int i = 1; i < 9; i++) write_byte(msg[i], (i == 8), 1'b1);
        for (int i = 0; i < 60 && done8_cnt == 0; i++) begin
            @(posedge clk);
            #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("bpc8_latency", done8_cyc - w_cyc, 19);
        check("bpc8_value", crc_value8, 16'h29B1);
        check("bpc8_frames", done8_cnt, 1);

`ifdef CRC_FRAME_CHECK_EN
        base = done_cnt;
        crc_exp = 16'h29B1;
        write_msg(1'b0);
        wait_done(base + 1, 200);
        check("match_hit", crc_match, 1);
        crc_exp = 16'h29B0;
        write_msg(1'b0);
        wait_done(base + 2, 200);
        check("match_miss", crc_match, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
